imem_boot_loader: RTL and testbench

Controller that sequences instruction-memory loading for the IF stage before the core runs. It receives a byte stream over a valid/ready handshake, which can be fed by a UART receiver or a test harness. It assembles little-endian 32-bit words, drives the IF stage's instruction-memory write port (addr/data/wren), and holds the core in reset until a checksummed image has loaded. It reports done/error status to top level.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_word_packer.sv | 34 +++
 rtl/imem_boot_loader.sv | 144 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states and error codes.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] inst_mem_write_addr;
  logic [31:0] inst_mem_write_data;
  logic        inst_mem_wren;

  // master: the byte source / harness side that also observes the write port
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, inst_mem_write_addr, inst_mem_write_data, inst_mem_wren
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, inst_mem_write_addr, inst_mem_write_data, inst_mem_wren
  );

endinterface

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler with running XOR of every accepted byte.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [1:0]  o_idx,
  output logic [7:0]  o_xor
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic [7:0]  r_xor;

  // Bytes enter at the top and shift down, so after four the first byte sits in [7:0].
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
      r_xor  <= '0;
    end else if (i_accept) begin
      r_word <= {i_byte, r_word[31:8]};
      r_idx  <= r_idx + 2'd1;
      r_xor  <= r_xor ^ i_byte;
    end
  end

  assign o_word = r_word;
  assign o_idx  = r_idx;
  assign o_xor  = r_xor;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed image into instruction memory and
// holds the core in reset until the image is verified.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  imem_boot_loader_if.slave    bus,
  output logic                 core_hold,
  output logic                 load_busy,
  output logic                 load_done,
  output logic                 load_err,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     words_loaded
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e           r_state, w_state_next;
  logic [TW-1:0]    r_tmo;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_words;
  logic [1:0]       r_err, w_err_next;
  logic [31:0]      r_addr, r_data;

  logic             w_waiting, w_accept, w_start, w_wren;
  logic [CNT_W-1:0] w_len_full;
  logic [31:0]      w_word, w_cur_addr;
  logic [1:0]       w_idx;
  logic [7:0]       w_xor;

  imem_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start),
    .i_accept (w_accept && (r_state == DATA)),
    .i_byte   (bus.rx_data),
    .o_word   (w_word),
    .o_idx    (w_idx),
    .o_xor    (w_xor)
  );

  assign w_waiting  = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                      (r_state == DATA)   || (r_state == CSUM);
  assign w_accept   = w_waiting && bus.rx_valid;
  assign w_len_full = CNT_W'({bus.rx_data, r_len[7:0]});
  assign w_cur_addr = 32'({r_words, 2'b00});

  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    w_start      = 1'b0;
    w_wren       = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          w_state_next = LEN_LO;
          w_err_next   = ERR_NONE;
          w_start      = 1'b1;
        end
      end
      LEN_LO: if (w_accept) w_state_next = LEN_HI;
      LEN_HI: begin
        if (w_accept) begin
          if ((w_len_full == '0) || (w_len_full > CNT_W'(MAX_WORDS))) begin
            w_state_next = ERR;
            w_err_next   = ERR_LEN;
          end else begin
            w_state_next = DATA;
          end
        end
      end
      DATA: if (w_accept && (w_idx == 2'd3)) w_state_next = WRITE;
      WRITE: begin
        w_wren       = 1'b1;
        w_state_next = ((r_words + CNT_W'(1)) == r_len) ? CSUM : DATA;
      end
      CSUM: begin
        if (w_accept) begin
          if (bus.rx_data == w_xor) begin
            w_state_next = DONE;
          end else begin
            w_state_next = ERR;
            w_err_next   = ERR_CSUM;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    // The timeout lands on the same edge as the last idle cycle, so rx_ready is already low in ERR.
    if (w_waiting && !w_accept && (r_tmo == TMO_LAST)) begin
      w_state_next = ERR;
      w_err_next   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tmo   <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_err   <= ERR_NONE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_start || w_accept || (w_state_next != r_state)) begin
        r_tmo <= '0;
      end else if (w_waiting) begin
        r_tmo <= r_tmo + TW'(1);
      end
      if (w_accept && (r_state == LEN_LO)) r_len[7:0] <= bus.rx_data;
      if (w_accept && (r_state == LEN_HI)) r_len <= w_len_full;
      if (w_start) begin
        r_words <= '0;
      end else if (r_state == WRITE) begin
        r_words <= r_words + CNT_W'(1);
        r_addr  <= w_cur_addr;
        r_data  <= w_word;
      end
    end
  end

  assign bus.rx_ready            = w_waiting;
  assign bus.inst_mem_wren       = w_wren;
  assign bus.inst_mem_write_addr = (r_state == WRITE) ? w_cur_addr : r_addr;
  assign bus.inst_mem_write_data = (r_state == WRITE) ? w_word : r_data;

  assign core_hold    = (r_state != IDLE) && (r_state != DONE);
  assign load_busy    = (r_state != IDLE) && (r_state != DONE) && (r_state != ERR);
  assign load_done    = (r_state == DONE);
  assign load_err     = (r_state == ERR);
  assign err_code     = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized image loads checked against a byte-level model of the frame rules.
module tb_imem_boot_loader;

  localparam int MAX_W = 8;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        core_hold, load_busy, load_done, load_err;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  imem_boot_loader_if bus ();

  imem_boot_loader #(.MAX_WORDS(MAX_W), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .bus          (bus),
    .core_hold    (core_hold),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .load_err     (load_err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] img[16];

  always @(negedge clk) begin
    if (bus.inst_mem_wren) begin
      q_addr.push_back(bus.inst_mem_write_addr);
      q_data.push_back(bus.inst_mem_write_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) break;
      waited++;
      if (waited > 50) break;
    end
    check("handshake_bound", {31'd0, waited > 50}, 32'd0);
    tick();
    bus.rx_valid = 1'b0;
  endtask

  function automatic int rnd_gap(input int gmax);
    return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
  endfunction

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    check({pfx, "_wren"}, {31'd0, bus.inst_mem_wren}, 32'd0);
    check({pfx, "_addr"}, bus.inst_mem_write_addr, 32'd0);
    check({pfx, "_data"}, bus.inst_mem_write_data, 32'd0);
    check({pfx, "_hold"}, {31'd0, core_hold}, 32'd0);
    check({pfx, "_busy"}, {31'd0, load_busy}, 32'd0);
    check({pfx, "_done"}, {31'd0, load_done}, 32'd0);
    check({pfx, "_err"}, {31'd0, load_err}, 32'd0);
    check({pfx, "_code"}, {30'd0, err_code}, 32'd0);
    check({pfx, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  // Model: a frame writes word i to byte address 4*i; only data bytes enter the XOR.
  task automatic do_load(input string tag, input logic [15:0] n_field,
                         input logic [7:0] csum_delta, input int gmax);
    logic [7:0] acc = 8'd0;
    logic [7:0] b;
    bit         n_ok;
    int         nw, nchk;
    logic [1:0] exp_err;
    q_addr.delete();
    q_data.delete();
    pulse_start();
    check({tag, "_start_busy"}, {31'd0, load_busy}, 32'd1);
    check({tag, "_start_hold"}, {31'd0, core_hold}, 32'd1);
    check({tag, "_start_code"}, {30'd0, err_code}, 32'd0);
    send_byte(n_field[7:0], rnd_gap(gmax));
    send_byte(n_field[15:8], rnd_gap(gmax));
    n_ok = (n_field != 16'd0) && (int'(n_field) <= MAX_W);
    nw   = n_ok ? int'(n_field) : 0;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        b   = img[w][8*k +: 8];
        acc = acc ^ b;
        send_byte(b, rnd_gap(gmax));
      end
    end
    if (n_ok) send_byte(acc ^ csum_delta, rnd_gap(gmax));
    exp_err = !n_ok ? 2'd1 : ((csum_delta != 8'd0) ? 2'd2 : 2'd0);
    check({tag, "_wren_count"}, q_addr.size(), nw);
    nchk = (q_addr.size() < nw) ? q_addr.size() : nw;
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), q_addr[i], 32'(i * 4));
      check($sformatf("%s_wr%0d_data", tag, i), q_data[i], img[i]);
    end
    check({tag, "_done"}, {31'd0, load_done}, {31'd0, exp_err == 2'd0});
    check({tag, "_err"}, {31'd0, load_err}, {31'd0, exp_err != 2'd0});
    check({tag, "_code"}, {30'd0, err_code}, {30'd0, exp_err});
    check({tag, "_hold"}, {31'd0, core_hold}, {31'd0, exp_err != 2'd0});
    check({tag, "_busy"}, {31'd0, load_busy}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'(nw));
    check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
  endtask

  initial begin
    logic [7:0] acc;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;

    repeat (3) tick();
    check_all_zero("reset");

    // Reset wins over a coincident start request.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("rst_vs_start_busy", {31'd0, load_busy}, 32'd0);
    check("rst_vs_start_hold", {31'd0, core_hold}, 32'd0);
    rst = 1'b0;
    tick();

    img[0] = 32'h00500093;
    do_load("single", 16'd1, 8'h00, 0);

    img[0] = $urandom;
    img[1] = $urandom;
    do_load("two_gaps", 16'd2, 8'h00, 5);

    do_load("len_zero", 16'd0, 8'h00, 0);
    do_load("len_over", 16'(MAX_W + 1), 8'h00, 0);

    img[0] = 32'h00500093;
    do_load("csum_bad", 16'd1, 8'h01, 0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < MAX_W; i++) img[i] = $urandom;
      do_load($sformatf("rand%0d", t), 16'($urandom_range(MAX_W, 1)),
              (t == 0 || $urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1)), 3);
    end

    // Stream stalls after the third data byte; error must land exactly TMO idle cycles later.
    q_addr.delete();
    q_data.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k == TMO - 1) begin
        check("tmo_before_err", {31'd0, load_err}, 32'd0);
        check("tmo_before_ready", {31'd0, bus.rx_ready}, 32'd1);
      end
    end
    check("tmo_err", {31'd0, load_err}, 32'd1);
    check("tmo_code", {30'd0, err_code}, 32'd3);
    check("tmo_ready", {31'd0, bus.rx_ready}, 32'd0);
    bus.rx_valid = 1'b1;
    repeat (3) tick();
    check("tmo_ready_later", {31'd0, bus.rx_ready}, 32'd0);
    check("tmo_hold", {31'd0, core_hold}, 32'd1);
    check("tmo_no_wren", q_addr.size(), 32'd0);
    bus.rx_valid = 1'b0;

    // Reset in the middle of the second word of a two-word image.
    img[0] = $urandom;
    img[1] = $urandom;
    q_addr.delete();
    q_data.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
    send_byte(img[1][7:0], 1);
    send_byte(img[1][15:8], 0);
    rst = 1'b1;
    tick();
    check_all_zero("mid_rst");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("mid_rst_wren_count", q_addr.size(), 32'd1);

    // A start pulse inside DATA must not restart the frame.
    img[0] = $urandom;
    acc = img[0][7:0] ^ img[0][15:8] ^ img[0][23:16] ^ img[0][31:24];
    q_addr.delete();
    q_data.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(img[0][7:0], 0);
    send_byte(img[0][15:8], 0);
    pulse_start();
    send_byte(img[0][23:16], 0);
    send_byte(img[0][31:24], 0);
    send_byte(acc, 0);
    check("busy_start_wren_count", q_addr.size(), 32'd1);
    if (q_addr.size() > 0) begin
      check("busy_start_addr", q_addr[0], 32'd0);
      check("busy_start_data", q_data[0], img[0]);
    end
    check("busy_start_done", {31'd0, load_done}, 32'd1);
    check("busy_start_words", {16'd0, words_loaded}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
